// File: rtl/data_sram_arbiter.sv
// Two-port arbiter for the single-port data SRAM.
// Port 0 has priority; port 1 is forced through after MAX_WAIT denials.
module data_sram_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_WAIT   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    p0_req,
  input  logic                    p0_we,
  input  logic [ADDR_WIDTH-1:0]   p0_addr,
  input  logic [DATA_WIDTH-1:0]   p0_wdata,
  input  logic [DATA_WIDTH/8-1:0] p0_be,
  output logic                    p0_gnt,
  output logic                    p0_rvalid,
  output logic [DATA_WIDTH-1:0]   p0_rdata,
  input  logic                    p1_req,
  input  logic                    p1_we,
  input  logic [ADDR_WIDTH-1:0]   p1_addr,
  input  logic [DATA_WIDTH-1:0]   p1_wdata,
  input  logic [DATA_WIDTH/8-1:0] p1_be,
  output logic                    p1_gnt,
  output logic                    p1_rvalid,
  output logic [DATA_WIDTH-1:0]   p1_rdata,
  output logic                    sram_en,
  output logic                    sram_we,
  output logic [ADDR_WIDTH-1:0]   sram_addr,
  output logic [DATA_WIDTH-1:0]   sram_wdata,
  output logic [DATA_WIDTH/8-1:0] sram_be,
  input  logic [DATA_WIDTH-1:0]   sram_rdata,
  output logic                    p1_starved
);

  localparam int BW = DATA_WIDTH / 8;
  localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

  typedef enum logic {
    PRIO_P0,
    FORCE_P1
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       pending, owner;

  // Grants are masked during reset so no access slips through
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      if (state == PRIO_P0) begin
        p0_gnt = p0_req;
        p1_gnt = p1_req && !p0_req;
      end else begin
        p1_gnt = p1_req;
        p0_gnt = p0_req && !p1_req;
      end
    end
  end

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    sram_be    = '0;
    if (p0_gnt) begin
      sram_en    = 1'b1;
      sram_we    = p0_we;
      sram_addr  = p0_addr;
      sram_wdata = p0_wdata;
      sram_be    = p0_we ? p0_be : {BW{1'b1}};
    end else if (p1_gnt) begin
      sram_en    = 1'b1;
      sram_we    = p1_we;
      sram_addr  = p1_addr;
      sram_wdata = p1_wdata;
      sram_be    = p1_we ? p1_be : {BW{1'b1}};
    end
  end

  always_comb begin
    wait_nxt  = wait_cnt;
    state_nxt = state;
    if (!p1_req || p1_gnt) begin
      wait_nxt = 4'd0;
    end else if (wait_cnt < MAX_W) begin
      wait_nxt = wait_cnt + 4'd1;
    end
    unique case (state)
      PRIO_P0: begin
        if (wait_nxt == MAX_W) state_nxt = FORCE_P1;
      end
      FORCE_P1: begin
        if (p1_gnt || !p1_req) state_nxt = PRIO_P0;
      end
      default: state_nxt = PRIO_P0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PRIO_P0;
      wait_cnt <= 4'd0;
      pending  <= 1'b0;
      owner    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      pending  <= sram_en && !sram_we;
      owner    <= p1_gnt;
    end
  end

  assign p1_starved = (state == FORCE_P1);
  assign p0_rvalid  = pending && !owner;
  assign p1_rvalid  = pending && owner;
  assign p0_rdata   = p0_rvalid ? sram_rdata : '0;
  assign p1_rdata   = p1_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_data_sram_arbiter.sv
// Directed bench for data_sram_arbiter with a behavioural SRAM macro.
// Inputs change on negedge; combinational and registered outputs are sampled off-edge.
module tb_data_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_req, p0_we;
  logic [9:0]  p0_addr;
  logic [31:0] p0_wdata;
  logic [3:0]  p0_be;
  logic        p0_gnt, p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p1_req, p1_we;
  logic [9:0]  p1_addr;
  logic [31:0] p1_wdata;
  logic [3:0]  p1_be;
  logic        p1_gnt, p1_rvalid;
  logic [31:0] p1_rdata;
  logic        sram_en, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata;
  logic [3:0]  sram_be;
  logic [31:0] sram_rdata;
  logic        p1_starved;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [0:1023];

  always #5 clk = ~clk;

  data_sram_arbiter #(
    .ADDR_WIDTH(10), .DATA_WIDTH(32), .MAX_WAIT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr),
    .p0_wdata(p0_wdata), .p0_be(p0_be),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr),
    .p1_wdata(p1_wdata), .p1_be(p1_be),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_be(sram_be),
    .sram_rdata(sram_rdata), .p1_starved(p1_starved)
  );

  // SRAM macro: byte-masked write, 1-cycle registered read
  always_ff @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_be[b]) mem[sram_addr][b*8 +: 8] <= sram_wdata[b*8 +: 8];
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_p0(input logic req, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d; p0_be = be;
  endtask

  task automatic set_p1(input logic req, input logic we, input logic [9:0] a,
                        input logic [31:0] d, input logic [3:0] be);
    p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d; p1_be = be;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    sram_rdata = 32'h0;
    rst = 1'b1;
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    @(negedge clk);
    tick();
    #1;
    chk("rst_p0_rvalid", {31'b0, p0_rvalid}, 0);
    chk("rst_p1_rvalid", {31'b0, p1_rvalid}, 0);
    chk("rst_starved", {31'b0, p1_starved}, 0);
    chk("rst_sram_en", {31'b0, sram_en}, 0);
    @(negedge clk);
    rst = 1'b0;

    // p0 write then read back
    set_p0(1, 1, 10'h010, 32'hDEADBEEF, 4'hF);
    #1;
    chk("t1_wr_gnt", {31'b0, p0_gnt}, 1);
    chk("t1_wr_we", {31'b0, sram_we}, 1);
    chk("t1_wr_addr", {22'b0, sram_addr}, 32'h010);
    tick();
    set_p0(1, 0, 10'h010, 32'h0, 4'h0);
    #1;
    chk("t1_rd_gnt", {31'b0, p0_gnt}, 1);
    chk("t1_rd_be", {28'b0, sram_be}, 32'hF);
    chk("t1_rd_we", {31'b0, sram_we}, 0);
    tick();
    set_p0(0, 0, 0, 0, 0);
    chk("t1_rvalid", {31'b0, p0_rvalid}, 1);
    chk("t1_rdata", p0_rdata, 32'hDEADBEEF);
    chk("t1_p1_rvalid", {31'b0, p1_rvalid}, 0);
    #1;
    chk("t1_idle_en", {31'b0, sram_en}, 0);
    chk("t1_idle_addr", {22'b0, sram_addr}, 0);
    tick();
    chk("t1_rvalid_drop", {31'b0, p0_rvalid}, 0);

    // both held: p1 wins every 5th cycle
    set_p0(1, 0, 10'h010, 0, 0);
    set_p1(1, 0, 10'h011, 0, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t2_p0_gnt%0d", i), {31'b0, p0_gnt}, (i % 5 != 4) ? 1 : 0);
      chk($sformatf("t2_p1_gnt%0d", i), {31'b0, p1_gnt}, (i % 5 == 4) ? 1 : 0);
      chk($sformatf("t2_starved%0d", i), {31'b0, p1_starved},
          (i % 5 == 4) ? 1 : 0);
      tick();
    end
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    tick();

    // alternating reads
    set_p0(1, 1, 10'h001, 32'h11111111, 4'hF);
    tick();
    set_p0(0, 0, 0, 0, 0);
    set_p1(1, 1, 10'h002, 32'h22222222, 4'hF);
    tick();
    set_p1(0, 0, 0, 0, 0);
    set_p0(1, 0, 10'h001, 0, 0);
    #1;
    chk("t3_p0_gnt", {31'b0, p0_gnt}, 1);
    tick();
    set_p0(0, 0, 0, 0, 0);
    set_p1(1, 0, 10'h002, 0, 0);
    chk("t3_p0_rvalid", {31'b0, p0_rvalid}, 1);
    chk("t3_p0_rdata", p0_rdata, 32'h11111111);
    chk("t3_p1_rvalid_a", {31'b0, p1_rvalid}, 0);
    #1;
    chk("t3_p1_gnt", {31'b0, p1_gnt}, 1);
    tick();
    set_p1(0, 0, 0, 0, 0);
    chk("t3_p1_rvalid", {31'b0, p1_rvalid}, 1);
    chk("t3_p1_rdata", p1_rdata, 32'h22222222);
    chk("t3_p0_rvalid_b", {31'b0, p0_rvalid}, 0);
    chk("t3_p0_rdata_b", p0_rdata, 32'h0);
    tick();

    // byte-enable write from p1
    set_p1(1, 1, 10'h020, 32'hAABBCCDD, 4'b0101);
    #1;
    chk("t4_be", {28'b0, sram_be}, 32'h5);
    tick();
    set_p1(1, 0, 10'h020, 0, 0);
    tick();
    set_p1(0, 0, 0, 0, 0);
    chk("t4_rvalid", {31'b0, p1_rvalid}, 1);
    chk("t4_rdata", p1_rdata, 32'h00BB00DD);
    tick();

    // starve p1, then withdraw before its grant
    set_p0(1, 0, 10'h010, 0, 0);
    set_p1(1, 0, 10'h011, 0, 0);
    repeat (4) tick();
    chk("t5_starved", {31'b0, p1_starved}, 1);
    set_p1(0, 0, 0, 0, 0);
    #1;
    chk("t5_wd_p0_gnt", {31'b0, p0_gnt}, 1);
    chk("t5_wd_p1_gnt", {31'b0, p1_gnt}, 0);
    tick();
    chk("t5_back_prio", {31'b0, p1_starved}, 0);
    set_p1(1, 0, 10'h011, 0, 0);
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("t5_p0_wins%0d", i), {30'b0, p1_gnt, p0_gnt}, 32'h1);
      tick();
    end
    chk("t5_restarved", {31'b0, p1_starved}, 1);

    // reset while starved and p0 reads
    rst = 1'b1;
    #1;
    chk("t6_p0_gnt", {31'b0, p0_gnt}, 0);
    chk("t6_p1_gnt", {31'b0, p1_gnt}, 0);
    chk("t6_sram_en", {31'b0, sram_en}, 0);
    tick();
    chk("t6_p0_rvalid", {31'b0, p0_rvalid}, 0);
    chk("t6_p1_rvalid", {31'b0, p1_rvalid}, 0);
    chk("t6_p0_rdata", p0_rdata, 32'h0);
    chk("t6_starved", {31'b0, p1_starved}, 0);
    set_p0(0, 0, 0, 0, 0);
    set_p1(0, 0, 0, 0, 0);
    rst = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
